// File: rtl/bit_unstuffer_rx.sv
// Receive-side bit unstuffer: removes the stuff bit that follows RUN_LEN consecutive ones.
// Optional macro STUFF_ERR_CHECK_EN turns a one in the stuff-bit slot into a sticky error state.
module bit_unstuffer_rx #(
    parameter int RUN_LEN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic shift_enable,
    input  logic clear,
    output logic serial_out,
    output logic shift_out,
    output logic stuff_drop,
    output logic stuff_error
);

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    localparam logic [2:0] RUN_MAX = 3'(RUN_LEN);

    state_t     state, state_n;
    logic [2:0] ones_cnt, ones_cnt_n;
    logic       serial_out_n, shift_out_n, stuff_drop_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            ones_cnt   <= 3'd0;
            serial_out <= 1'b0;
            shift_out  <= 1'b0;
            stuff_drop <= 1'b0;
        end else begin
            state      <= state_n;
            ones_cnt   <= ones_cnt_n;
            serial_out <= serial_out_n;
            shift_out  <= shift_out_n;
            stuff_drop <= stuff_drop_n;
        end
    end

    always_comb begin
        state_n      = state;
        ones_cnt_n   = ones_cnt;
        serial_out_n = serial_out;
        shift_out_n  = 1'b0;
        stuff_drop_n = 1'b0;
        if (clear) begin
            // A bit arriving with clear belongs to the packet boundary and is discarded.
            state_n    = RUN;
            ones_cnt_n = 3'd0;
        end else if (shift_enable && state == RUN) begin
            if (ones_cnt < RUN_MAX) begin
                serial_out_n = serial_in;
                shift_out_n  = 1'b1;
                ones_cnt_n   = serial_in ? ones_cnt + 3'd1 : 3'd0;
            end else if (!serial_in) begin
                stuff_drop_n = 1'b1;
                ones_cnt_n   = 3'd0;
            end else begin
`ifdef STUFF_ERR_CHECK_EN
                state_n = ERR;
`else
                // Without checking, a one in the stuff slot is dropped like a legal stuff bit.
                stuff_drop_n = 1'b1;
                ones_cnt_n   = 3'd0;
`endif
            end
        end
    end

`ifdef STUFF_ERR_CHECK_EN
    assign stuff_error = (state == ERR);
`else
    assign stuff_error = 1'b0;
`endif

endmodule

// File: tb/tb_bit_unstuffer_rx.sv
// Directed scoreboard bench for bit_unstuffer_rx (RUN_LEN = 6); strobes are checked by a monitor
// against an expected queue of {stuff_drop, serial_out} pairs.
module tb_bit_unstuffer_rx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_in = 1'b0;
    logic shift_enable = 1'b0;
    logic clear = 1'b0;
    logic serial_out, shift_out, stuff_drop, stuff_error;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    // exp[2] = an output event is expected, exp[1] = it is a drop, exp[0] = serial_out value
    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] S0   = 3'b100;
    localparam logic [2:0] S1   = 3'b101;
    localparam logic [2:0] D1   = 3'b111;

    bit_unstuffer_rx #(.RUN_LEN(6)) dut (
        .clk(clk),
        .rst(rst),
        .serial_in(serial_in),
        .shift_enable(shift_enable),
        .clear(clear),
        .serial_out(serial_out),
        .shift_out(shift_out),
        .stuff_drop(stuff_drop),
        .stuff_error(stuff_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic b, input logic clr, input logic [2:0] exp);
        shift_enable = en;
        serial_in    = b;
        clear        = clr;
        if (exp[2]) exp_q.push_back(exp[1:0]);
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic ones(input int n, input logic [2:0] exp);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, exp);
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b0, 1'b1, NONE);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (shift_out === 1'b1 && stuff_drop === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL exclusive: shift_out and stuff_drop both high at %0t", $time);
        end else if (shift_out === 1'b1 || stuff_drop === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got drop=%b bit=%b, expected no event at %0t",
                         stuff_drop, serial_out, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if ({stuff_drop, serial_out} !== e) begin
                    errors++;
                    $display("FAIL strobe: got drop=%b bit=%b, expected drop=%b bit=%b at %0t",
                             stuff_drop, serial_out, e[1], e[0], $time);
                end
            end
        end
    end

    initial begin
        // Reset with a live bit present: the bit must be ignored.
        @(posedge clk);
        #1;
        rst = 1'b1; shift_enable = 1'b1; serial_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0;
        check("reset_outputs", {4'd0, serial_out, shift_out, stuff_drop, stuff_error}, 8'h00);

        // Stuffing: six ones, stuff zero dropped, trailing one passed.
        ones(6, S1);
        drive(1'b1, 1'b0, 1'b0, D1);
        check("drop_keeps_serial_out", {7'd0, serial_out}, 8'h01);
        drive(1'b1, 1'b1, 1'b0, S1);

        // No stuff: the zero arrives after five ones and is data.
        do_clear();
        check("clear_holds_serial_out", {7'd0, serial_out}, 8'h01);
        ones(5, S1);
        drive(1'b1, 1'b0, 1'b0, S0);
        ones(2, S1);

        // A one in the stuff slot.
        do_clear();
        ones(6, S1);
`ifdef STUFF_ERR_CHECK_EN
        drive(1'b1, 1'b1, 1'b0, NONE);
        check("stuff_error_set", {7'd0, stuff_error}, 8'h01);
        ones(2, NONE);
        drive(1'b1, 1'b0, 1'b0, NONE);
        check("stuff_error_sticky", {7'd0, stuff_error}, 8'h01);
        do_clear();
        check("stuff_error_cleared", {7'd0, stuff_error}, 8'h00);
        drive(1'b1, 1'b0, 1'b0, S0);
`else
        drive(1'b1, 1'b1, 1'b0, D1);
        check("stuff_error_tied_low", {7'd0, stuff_error}, 8'h00);
        drive(1'b1, 1'b0, 1'b0, S0);
`endif
        check("serial_out_after_zero", {7'd0, serial_out}, 8'h00);

        // Clear collides with a bit: the bit is discarded and the run restarts.
        do_clear();
        ones(5, S1);
        drive(1'b1, 1'b1, 1'b1, NONE);
        check("collision_no_strobe", {6'd0, shift_out, stuff_drop}, 8'h00);
        ones(6, S1);
        drive(1'b1, 1'b0, 1'b0, D1);

        // Gapped enables: outputs hold through idle cycles.
        do_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, S1);
            for (int g = 0; g < 3; g++) drive(1'b0, 1'b0, 1'b0, NONE);
            check("gap_holds_serial_out", {7'd0, serial_out}, 8'h01);
        end
        drive(1'b1, 1'b0, 1'b0, D1);
        check("gap_drop_serial_out", {7'd0, serial_out}, 8'h01);
        drive(1'b0, 1'b0, 1'b0, NONE);

        // Reset mid-run must restart the ones count.
        ones(3, S1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, NONE);
        rst = 1'b0;
        check("midrun_reset", {4'd0, serial_out, shift_out, stuff_drop, stuff_error}, 8'h00);
        ones(6, S1);
        drive(1'b1, 1'b0, 1'b0, D1);
        drive(1'b0, 1'b0, 1'b0, NONE);
        drive(1'b0, 1'b0, 1'b0, NONE);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expected events never seen, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_unstuffer_rx.md
BIT_UNSTUFFER_RX -- requirements
Module: bit_unstuffer_RX

Interface
REQ-001 SHALL have parameter RUN_LEN, default 6, meaning the number of consecutive 1 bits after which the next received bit is a stuff bit (legal range 2..7).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port serial_in, input, 1 bit: NRZI-decoded receive bit.
REQ-005 SHALL have port shift_enable, input, 1 bit: serial_in is valid and consumed this cycle.
REQ-006 SHALL have port clear, input, 1 bit: packet boundary (SYNC/EOP); restarts run tracking.
REQ-007 SHALL have port serial_out, output, 1 bit: registered data bit toward the receive shift register.
REQ-008 SHALL have port shift_out, output, 1 bit: single-cycle strobe, serial_out holds a valid data bit.
REQ-009 SHALL have port stuff_drop, output, 1 bit: single-cycle pulse, a stuff bit was removed.
REQ-010 SHALL have port stuff_error, output, 1 bit: sticky, stuff-rule violation detected.

Function
REQ-011 SHALL keep a 3-bit ones counter (ones_cnt), saturating at RUN_LEN, and a two-state FSM: RUN, ERR.
REQ-012 In RUN with shift_enable=1 and ones_cnt<RUN_LEN: serial_in SHALL be passed to serial_out and shift_out=1 the following cycle (latency 1); ones_cnt increments on 1, resets to 0 on 0.
REQ-013 In RUN with shift_enable=1, ones_cnt==RUN_LEN and serial_in=0: bit SHALL be dropped; shift_out=0, stuff_drop=1 next cycle; ones_cnt <= 0.
REQ-014 In RUN with shift_enable=1, ones_cnt==RUN_LEN and serial_in=1: behaviour SHALL follow REQ-022/REQ-023.
REQ-015 In ERR: shift_out and stuff_drop SHALL stay 0 regardless of shift_enable; stuff_error SHALL stay 1; exit only via clear or rst.
REQ-016 With shift_enable=0: shift_out and stuff_drop SHALL be 0 next cycle; serial_out, ones_cnt, state SHALL hold.
REQ-017 clear=1 SHALL, at the next edge, force RUN, ones_cnt=0, stuff_error=0, shift_out=0, stuff_drop=0; serial_out holds.
REQ-018 clear and shift_enable in the same cycle: clear SHALL win; the bit is discarded and not counted.
REQ-019 shift_out and stuff_drop SHALL never be 1 in the same cycle.
REQ-020 Back-to-back shift_enable on every cycle SHALL be supported with no lost bits.

Reset
REQ-021 rst=1 at a rising edge SHALL set state=RUN, ones_cnt=0, serial_out=0, shift_out=0, stuff_drop=0, stuff_error=0; rst overrides clear and shift_enable, including mid-run or in ERR.

Configuration
REQ-022 With macro STUFF_ERR_CHECK_EN defined: the case of REQ-014 SHALL set stuff_error=1 next cycle, enter ERR, and drop the bit (shift_out=0, stuff_drop=0).
REQ-023 Without STUFF_ERR_CHECK_EN: stuff_error SHALL be tied 0, state ERR unreachable; the case of REQ-014 SHALL be treated as REQ-013 (bit dropped, stuff_drop=1, ones_cnt <= 0).

Verification
REQ-024 Reset: rst=1 one cycle with shift_enable=1, serial_in=1 -> all outputs 0 next cycle, ones_cnt=0.
REQ-025 Stuffing: bits 1,1,1,1,1,1,0,1 on consecutive enables -> shift_out on 6 ones then on trailing 1; stuff_drop pulses once for the 0; serial_out sequence 1,1,1,1,1,1,1.
REQ-026 No stuff: bits 1,1,1,1,1,0,1,1 -> eight shift_out strobes, stuff_drop never asserted.
REQ-027 Error (macro defined): seven 1s -> six shift_out strobes, stuff_error=1 one cycle after 7th bit, no further shift_out; clear=1 -> stuff_error=0, next bit 0 yields shift_out=1, serial_out=0.
REQ-028 Clear collision: five 1s, then clear=1 with shift_enable=1, serial_in=1, then six 1s and a 0 -> no shift_out for collided bit, stuff_drop only on the final 0.
REQ-029 Gapped enables: six 1s with shift_enable=0 for 3 cycles between each, then 0 -> outputs hold in gaps, stuff_drop=1 once, serial_out unchanged by the drop.
